jk_seq_detector: RTL and testbench
==================================

# jk_seq_detector

Serial-bitstream sequence detector whose state register is built from JK flip-flop cells, with a KMP-style prefix-match state machine. It sits directly upstream of the JK storage stage: it computes the next matched-prefix length and drives the J/K excitation of each state cell. It emits a one-cycle detect pulse and keeps a saturating detection count. It is the standard front end for the sequence-detector family.

## Interface
- PATTERN_W, default 4: pattern length in bits, 1..8.
- PATTERN, default 4'b1011: target sequence. The MSB is the first bit received.
- CNT_W, default 8: width of the detection counter.
- STATE_W, derived as clog2(PATTERN_W+1): state width. Not user-set.

- clk  in  1  rising-edge clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of state, pulse and counter.
- din_valid  in  1  din is sampled on this edge.
- din  in  1  serial data bit.
- detect  out  1  one-cycle pulse; the full pattern was matched.
- match_len  out  STATE_W  current matched-prefix length, 0..PATTERN_W.
- det_count  out  CNT_W  saturating count of detections.

## Operation
- State S = number of pattern bits currently matched. Range 0..PATTERN_W. Encoded in binary across STATE_W JK cells.
- Next state on a valid bit b:
  - If S<PATTERN_W and b equals PATTERN bit S (counting from the MSB), next = S+1.
  - Otherwise next = the longest proper prefix of the pattern that is a suffix of (matched prefix, b), using the KMP failure function.
- Excitation per cell i: J_i = ~Q_i & N_i and K_i = Q_i & ~N_i, where N is the next state. When din_valid=0, all J=K=0, so the state holds. J=K=1 (toggle) is never generated.
- detect is registered and set on an edge where din_valid=1 and next state == PATTERN_W; it is cleared on every other edge.
- det_count increments on the same edge detect is set. At all-ones it holds; there is no wrap.
- clear has priority over din_valid. On a clear edge: S=0, detect=0, det_count=0, and the data bit is discarded.
- Reset (asynchronous, reset_n low): S=0, match_len=0, detect=0, det_count=0. This applies immediately, including mid-sequence. The first valid bit after reset release is treated as the first bit of a new stream.
- An out-of-range state is impossible by construction. Any encoding above PATTERN_W is treated as S=0 for next-state purposes.

## Timing
- Latency: detect and the det_count increment become visible one cycle after the edge that samples the final pattern bit.
- match_len is the register output. It reflects bits sampled up to and including the previous edge.
- din_valid gaps of any length are transparent to matching. detect never stretches beyond one cycle during a gap.
- Back-to-back detections are possible on consecutive valid bits only when the pattern allows it (e.g. all-ones with overlap on). Each detection gives a separate one-cycle pulse.

## Configuration
- SEQ_DET_OVERLAP_EN defined: overlapping detection. From S=PATTERN_W, the next state follows the KMP failure transition, so a match's suffix can start the next match.
- SEQ_DET_OVERLAP_EN undefined: non-overlapping detection. From S=PATTERN_W, the next state is computed exactly as if S were 0.

## Structure
- seq_det_pkg holds:
  - the clog2 function;
  - a next_state(state, bit, pattern, width) function, evaluated at elaboration into a constant transition table of 2*(PATTERN_W+1) entries;
  - the maximum PATTERN_W constant (8).
- Sub-module jk_cell: one JK flip-flop with active-low asynchronous reset to 0, ports clk, reset_n, j, k, q. It is instantiated STATE_W times in a generate loop.
- The top level contains the excitation logic, the detect register and the counter.

## Test plan
- Overlap on, PATTERN=1011, stream 1011011 all valid: detect pulses after bits 4 and 7, det_count=2, match_len=4 after bit 7.
- Overlap off, same stream: one pulse after bit 4, det_count=1, match_len=1 after bit 7.
- Stream 1,0,(din_valid=0 for 5 cycles),1,1: single pulse one cycle after the last bit; match_len holds at 2 during the gap.
- CNT_W=2, overlap on, PATTERN=11, eight valid 1s: 7 detect pulses; det_count=3 after the third pulse and stays 3.
- Send 101, assert reset_n low for one cycle mid-cycle, then send 1: all outputs 0 immediately, no detect, match_len=1.
- clear and din_valid=1 with the final 1 of 1011 on the same edge: detect=0, match_len=0, det_count=0.

Source files
------------

// File: rtl/jk_seq_detector_pkg.sv
// Shared constants and elaboration-time helpers for the JK-based sequence detector.
// The KMP transition function here is only ever evaluated into constant tables.
package seq_det_pkg;

    localparam int MAX_PATTERN_W = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // Longest pattern prefix that is a suffix of (matched prefix, b); out-of-range states behave as 0.
    function automatic int next_state(input int state, input logic b,
                                      input logic [MAX_PATTERN_W-1:0] pattern, input int width);
        int   s;
        int   len;
        int   res;
        int   pos;
        logic ok;
        logic ch;
        s   = (state > width || state < 0) ? 0 : state;
        len = s + 1;
        res = 0;
        for (int k = MAX_PATTERN_W; k >= 1; k--) begin
            if (res == 0 && k <= width && k <= len) begin
                ok = 1'b1;
                for (int i = 0; i < MAX_PATTERN_W; i++) begin
                    if (i < k) begin
                        pos = len - k + i;
                        ch  = (pos < s) ? pattern[3'(width - 1 - pos)] : b;
                        if (ch != pattern[3'(width - 1 - i)]) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    res = k;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/jk_seq_detector_jk_cell.sv
// Single JK flip-flop used as one bit of the detector state register.
// Asynchronous active-low reset clears the cell to 0.
module jk_cell (
    input  logic clk,
    input  logic reset_n,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b10:   q <= 1'b1;
                2'b01:   q <= 1'b0;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_seq_detector.sv
// Serial sequence detector: KMP prefix-match state held in JK cells, detect pulse and saturating count.
// Define SEQ_DET_OVERLAP_EN for overlapping detection; default build is non-overlapping.
module jk_seq_detector
    import seq_det_pkg::*;
#(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter int                   CNT_W     = 8,
    localparam int                  STATE_W   = clog2(PATTERN_W + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               din_valid,
    input  logic               din,
    output logic               detect,
    output logic [STATE_W-1:0] match_len,
    output logic [CNT_W-1:0]   det_count
);

`ifdef SEQ_DET_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    localparam int                       NUM_ENTRIES = 2 * (PATTERN_W + 1);
    localparam logic [MAX_PATTERN_W-1:0] PAT_EXT     = MAX_PATTERN_W'(PATTERN);
    localparam logic [STATE_W-1:0]       FULL        = STATE_W'(PATTERN_W);

    logic [STATE_W-1:0] w_table [NUM_ENTRIES];
    logic [STATE_W-1:0] w_q;
    logic [STATE_W-1:0] w_sIdx;
    logic [STATE_W:0]   w_idx;
    logic [STATE_W-1:0] w_n;
    logic [STATE_W-1:0] w_j;
    logic [STATE_W-1:0] w_k;
    logic               w_hit;
    logic               r_detect;
    logic [CNT_W-1:0]   r_count;

    // Without overlap, a full match restarts exactly like the empty state.
    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_table
        localparam int SRC = ((g / 2) == PATTERN_W && !OVERLAP) ? 0 : (g / 2);
        assign w_table[g] = STATE_W'(next_state(SRC, (g % 2) == 1, PAT_EXT, PATTERN_W));
    end

    assign w_sIdx = (w_q > FULL) ? '0 : w_q;
    assign w_idx  = {w_sIdx, din};

    always_comb begin
        w_n = w_q;
        if (clear) begin
            w_n = '0;
        end else if (din_valid) begin
            w_n = w_table[w_idx];
        end
    end

    assign w_j   = ~w_q & w_n;
    assign w_k   = w_q & ~w_n;
    assign w_hit = din_valid & ~clear & (w_table[w_idx] == FULL);

    for (genvar i = 0; i < STATE_W; i++) begin : g_cell
        jk_cell u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .j       (w_j[i]),
            .k       (w_k[i]),
            .q       (w_q[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_detect <= 1'b0;
            r_count  <= '0;
        end else if (clear) begin
            r_detect <= 1'b0;
            r_count  <= '0;
        end else begin
            r_detect <= w_hit;
            if (w_hit && r_count != '1) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign detect    = r_detect;
    assign match_len = w_q;
    assign det_count = r_count;

endmodule

// File: tb/tb_jk_seq_detector.sv
// Self-checking bench for jk_seq_detector against a bit-history reference model.
// Follows SEQ_DET_OVERLAP_EN the same way the design does.
module tb_jk_seq_detector;

    localparam int             W   = 4;
    localparam logic [W-1:0]   PAT = 4'b1011;
    localparam int             CW  = 8;
    localparam int             SW  = 3;

`ifdef SEQ_DET_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear;
    logic          din_valid;
    logic          din;
    logic          detect;
    logic [SW-1:0] match_len;
    logic [CW-1:0] det_count;

    int compareCnt = 0;
    int failCnt    = 0;

    bit hist[$];
    bit expDet;
    int expLen;
    int expCnt;

    always #5 clk = ~clk;

    jk_seq_detector #(
        .PATTERN_W (W),
        .PATTERN   (PAT),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .din_valid (din_valid),
        .din       (din),
        .detect    (detect),
        .match_len (match_len),
        .det_count (det_count)
    );

    // Longest pattern prefix that ends the received history.
    function automatic int longestMatch();
        for (int k = W; k >= 1; k--) begin
            if (k <= hist.size()) begin
                bit ok;
                ok = 1'b1;
                for (int i = 0; i < k; i++) begin
                    if (hist[hist.size() - k + i] != PAT[W-1-i]) ok = 1'b0;
                end
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    task automatic modelReset();
        hist.delete();
        expDet = 1'b0;
        expLen = 0;
        expCnt = 0;
    endtask

    task automatic modelStep(input bit v, input bit d, input bit c);
        if (c) begin
            modelReset();
        end else if (!v) begin
            expDet = 1'b0;
        end else begin
            hist.push_back(d);
            while (hist.size() > W) void'(hist.pop_front());
            if (longestMatch() == W) begin
                expDet = 1'b1;
                expLen = W;
                if (expCnt < (2 ** CW) - 1) expCnt++;
                if (!OVL) hist.delete();
            end else begin
                expDet = 1'b0;
                expLen = longestMatch();
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        compareCnt++;
        assert (detect === expDet) else begin
            failCnt++;
            $error("[TB] FAIL %s detect: observed %0b expected %0b", tag, detect, expDet);
        end
        compareCnt++;
        assert (match_len === SW'(expLen)) else begin
            failCnt++;
            $error("[TB] FAIL %s match_len: observed %0d expected %0d", tag, match_len, expLen);
        end
        compareCnt++;
        assert (det_count === CW'(expCnt)) else begin
            failCnt++;
            $error("[TB] FAIL %s det_count: observed %0d expected %0d", tag, det_count, expCnt);
        end
    endtask

    task automatic applyStimulus(input bit v, input bit d, input bit c, input string tag);
        @(negedge clk);
        din_valid = v;
        din       = d;
        clear     = c;
        @(posedge clk);
        modelStep(v, d, c);
        #1;
        checkOutput(tag);
    endtask

    task automatic sendBits(input logic [15:0] bits, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, bits[n-1-i], 1'b0, tag);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        clear     = 1'b0;
        din_valid = 1'b0;
        din       = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset");
        @(negedge clk);
        reset_n = 1'b1;

        sendBits(16'b1011011, 7, "stream7");
        applyStimulus(1'b0, 1'b0, 1'b0, "idleAfterStream");

        applyStimulus(1'b1, 1'b0, 1'b1, "clearIdle");
        sendBits(16'b101, 3, "prefixBeforeClear");
        applyStimulus(1'b1, 1'b1, 1'b1, "clearOnFinal");

        sendBits(16'b10, 2, "gapHead");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'($urandom % 2), 1'b0, "gap");
        end
        sendBits(16'b11, 2, "gapTail");
        applyStimulus(1'b0, 1'b0, 1'b0, "gapPulseEnd");

        sendBits(16'b101, 3, "preAsyncReset");
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("asyncReset");
        @(negedge clk);
        #2 reset_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, "firstAfterReset");
        applyStimulus(1'b0, 1'b0, 1'b0, "idleAfterReset");

        for (int i = 0; i < 270; i++) begin
            sendBits(16'b1011, 4, "saturate");
        end
        applyStimulus(1'b0, 1'b0, 1'b0, "saturatedHold");

        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, 1'($urandom % 2),
                          $urandom_range(0, 59) == 0, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, failCnt);
        $finish;
    end

endmodule
